// File: rtl/filter_zero_pad_if.sv
// filter_zero_pad_if: source pixel handshake in, padded pixel stream out
interface filter_zero_pad_if;
   logic        iValid;
   logic [23:0] iData;
   logic        oReady;
   logic        oValid;
   logic [23:0] oData;
   logic        oFrameDone;
   modport master(output iValid, iData, input oReady, oValid, oData, oFrameDone);
   modport slave(input iValid, iData, output oReady, oValid, oData, oFrameDone);
endinterface

// File: rtl/filter_zero_pad.sv
// filter_zero_pad: frames a raster RGB888 image with zero pad columns/rows plus flush rows
module filter_zero_pad #(
   parameter int IMG_WIDTH  = 320,
   parameter int IMG_HEIGHT = 240,
   parameter int PAD_COLS   = 1,
   parameter int PAD_ROWS   = 1,
   parameter int FLUSH_ROWS = 1
) (
   input logic              clk,
   input logic              reset,
   filter_zero_pad_if.slave bus
);
   localparam int ROW_LEN    = IMG_WIDTH + 2 * PAD_COLS;
   localparam int TOTAL_ROWS = IMG_HEIGHT + 2 * PAD_ROWS + FLUSH_ROWS;
   typedef enum logic [1:0] {IDLE, PAD, BODY} state_t;
   state_t      state;
   logic [12:0] row, col, nrow, ncol;
   logic        last, fire, row_end;
   function automatic logic is_body(input logic [12:0] r, input logic [12:0] c);
      return r >= 13'(PAD_ROWS) && r < 13'(PAD_ROWS + IMG_HEIGHT) &&
             c >= 13'(PAD_COLS) && c < 13'(PAD_COLS + IMG_WIDTH);
   endfunction
   assign bus.oReady = state == BODY;
   always_comb begin
      row_end = col == 13'(ROW_LEN - 1);
      last    = row_end && row == 13'(TOTAL_ROWS - 1);
      ncol    = row_end ? 13'd0 : col + 13'd1;
      nrow    = row_end ? row + 13'd1 : row;
      fire    = state == PAD || (state == BODY && bus.iValid);
   end
   // A stalled BODY cycle emits nothing and leaves the position untouched
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         row            <= '0;
         col            <= '0;
         bus.oValid     <= 1'b0;
         bus.oData      <= '0;
         bus.oFrameDone <= 1'b0;
      end else begin
         bus.oValid     <= fire;
         bus.oFrameDone <= fire && last;
         if (fire) bus.oData <= state == BODY ? bus.iData : '0;
         if (state == IDLE) begin
            if (bus.iValid) state <= is_body(row, col) ? BODY : PAD;
         end else if (fire) begin
            row   <= last ? '0 : nrow;
            col   <= last ? '0 : ncol;
            state <= last ? IDLE : is_body(nrow, ncol) ? BODY : PAD;
         end
      end
   end
endmodule

// File: tb/tb_filter_zero_pad.sv
// tb_filter_zero_pad: scoreboard bench over three pad geometries sharing one source and monitor
module tb_filter_zero_pad;
   logic        clk = 0, reset = 1;
   logic        src_valid = 0;
   logic [23:0] src_data = '0;
   int          sel = 0;
   logic        out_ready, out_valid, out_done;
   logic [23:0] out_data;
   logic [24:0] exp_q[$];
   logic [24:0] e;
   int n_checks = 0, n_fail = 0, hs = 0, dones = 0, cyc = 0;
   int pix_idx = 0, frame_len = 0, frame_first = 0, first_nz = -1, done_cyc = 0;
   bit chk_contig = 0, chk_gap = 0, gap_pending = 0, prev_done = 0;
   always #5 clk = ~clk;
   filter_zero_pad_if b0(), b1(), b2();
   assign b0.iValid = src_valid && sel == 0;
   assign b1.iValid = src_valid && sel == 1;
   assign b2.iValid = src_valid && sel == 2;
   assign b0.iData = src_data;
   assign b1.iData = src_data;
   assign b2.iData = src_data;
   assign out_ready = sel == 0 ? b0.oReady : sel == 1 ? b1.oReady : b2.oReady;
   assign out_valid = sel == 0 ? b0.oValid : sel == 1 ? b1.oValid : b2.oValid;
   assign out_data  = sel == 0 ? b0.oData : sel == 1 ? b1.oData : b2.oData;
   assign out_done  = sel == 0 ? b0.oFrameDone : sel == 1 ? b1.oFrameDone : b2.oFrameDone;
   filter_zero_pad #(.IMG_WIDTH(4), .IMG_HEIGHT(3)) u_small (.clk(clk), .reset(reset), .bus(b0));
   filter_zero_pad u_full (.clk(clk), .reset(reset), .bus(b1));
   filter_zero_pad #(.IMG_WIDTH(2), .IMG_HEIGHT(2), .PAD_COLS(2), .PAD_ROWS(2), .FLUSH_ROWS(0))
      u_wide (.clk(clk), .reset(reset), .bus(b2));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask
   // Reference frame: body pixels numbered base, base+1, ... in raster order
   task automatic push_frame(input int w, h, pc, pr, fr, base);
      int rl = w + 2 * pc, tr = h + 2 * pr + fr, k = 0;
      for (int r = 0; r < tr; r++)
         for (int c = 0; c < rl; c++) begin
            bit body = r >= pr && r < pr + h && c >= pc && c < pc + w;
            exp_q.push_back({1'(r == tr - 1 && c == rl - 1), body ? 24'(base + k) : 24'h0});
            if (body) k++;
         end
   endtask
   task automatic drive(input int base, input bit bursty, input int stop_after);
      int i = 0, n = 0;
      bit stalled = 0;
      while (i < stop_after && n < 100000) begin
         @(negedge clk);
         if (stalled) chk("stall_bubble", 32'(out_valid), 0);
         src_valid = bursty ? ~n[0] : 1'b1;
         src_data  = 24'(base + i);
         stalled   = out_ready && !src_valid;
         if (src_valid && out_ready) begin i++; hs++; end
         n++;
      end
      if (i < stop_after) chk("drive_timeout", i, stop_after);
      @(negedge clk);
      src_valid = 0;
   endtask
   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100000) begin @(negedge clk); n++; end
      chk("drain", exp_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask
   always @(posedge clk) begin
      #1;
      cyc++;
      if (reset) begin
         pix_idx = 0; gap_pending = 0; prev_done = 0;
      end else begin
         if (prev_done) chk("post_done_idle", 32'(out_valid), 0);
         if (out_valid) begin
            if (gap_pending) begin chk("b2b_gap", cyc - done_cyc, 2); gap_pending = 0; end
            if (pix_idx == 0) begin frame_first = cyc; first_nz = -1; end
            if (first_nz < 0 && out_data != 0) first_nz = pix_idx;
            if (exp_q.size() == 0) chk("extra_pixel", exp_q.size(), 1);
            else begin
               e = exp_q.pop_front();
               chk("pix_data", 32'(out_data), 32'(e[23:0]));
               chk("pix_done", 32'(out_done), 32'(e[24]));
            end
            pix_idx++;
         end else if (out_done) chk("done_without_valid", 32'(out_valid), 1);
         if (out_done) begin
            dones++; frame_len = pix_idx; done_cyc = cyc; gap_pending = chk_gap;
            if (chk_contig) chk("contig_len", cyc - frame_first + 1, pix_idx);
            pix_idx = 0;
         end
         prev_done = out_done;
      end
   end
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_done", 32'(out_done), 0);
      chk("rst_ready", 32'(out_ready), 0);
      reset = 0;
      chk_contig = 1; hs = 0; dones = 0;
      push_frame(4, 3, 1, 1, 1, 1);
      drive(1, 0, 12);
      drain();
      chk("t1_handshakes", hs, 12);
      chk("t1_done_count", dones, 1);
      chk("t1_len", frame_len, 36);
      chk_contig = 0; hs = 0; dones = 0;
      push_frame(4, 3, 1, 1, 1, 101);
      drive(101, 1, 12);
      drain();
      chk("t2_handshakes", hs, 12);
      chk("t2_done_count", dones, 1);
      sel = 1; chk_contig = 1; dones = 0;
      push_frame(320, 240, 1, 1, 1, 1);
      drive(1, 0, 320 * 240);
      drain();
      chk("t3_len", frame_len, 78246);
      chk("t3_first_active", first_nz, 323);
      chk("t3_done_count", dones, 1);
      sel = 0; chk_contig = 0; dones = 0;
      push_frame(4, 3, 1, 1, 1, 1);
      drive(1, 0, 6);
      reset = 1;
      @(negedge clk);
      chk("t4_rst_valid", 32'(out_valid), 0);
      chk("t4_rst_ready", 32'(out_ready), 0);
      reset = 0;
      exp_q.delete();
      dones = 0;
      push_frame(4, 3, 1, 1, 1, 51);
      drive(51, 0, 12);
      drain();
      chk("t4_done_count", dones, 1);
      chk("t4_len", frame_len, 36);
      chk_gap = 1; chk_contig = 1; dones = 0;
      push_frame(4, 3, 1, 1, 1, 1);
      push_frame(4, 3, 1, 1, 1, 13);
      drive(1, 0, 24);
      drain();
      chk_gap = 0; gap_pending = 0;
      chk("t5_done_count", dones, 2);
      sel = 2; dones = 0;
      push_frame(2, 2, 2, 2, 0, 1);
      drive(1, 0, 4);
      drain();
      chk("t6_len", frame_len, 36);
      chk("t6_done_count", dones, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/filter_zero_pad.md
# filter_zero_pad

Feeds the 3x3 filter stage with a padded pixel stream. Accepts a raster-order RGB888 frame through a valid/ready handshake and emits it framed by a zero border: zero pixels on the left and right of every row, zero rows above and below, plus trailing flush rows. The output row length matches the filter's row pipeline depth (`IMG_WIDTH + 2`). The output side has no backpressure, because the downstream filter consumes a pixel on every valid cycle.

## Interface

Parameters:
- `IMG_WIDTH`, default 320: active pixels per input row.
- `IMG_HEIGHT`, default 240: active rows per input frame.
- `PAD_COLS`, default 1: zero pixels inserted before and after each row.
- `PAD_ROWS`, default 1: zero rows inserted before and after the frame.
- `FLUSH_ROWS`, default 1: extra zero rows after the bottom pad, used to drain the downstream line buffer.

Ports:
- `clk`  in  1  the single clock.
- `reset`  in  1  synchronous, active-high reset.
- `iValid`  in  1  source has a pixel on `iData`.
- `iData`  in  24  pixel `{R[23:16], G[15:8], B[7:0]}`.
- `oReady`  out  1  block accepts `iData` this cycle; combinational from state.
- `oValid`  out  1  `oData` is valid (registered).
- `oData`  out  24  padded pixel stream (registered).
- `oFrameDone`  out  1  one-cycle pulse, coincident with the last output pixel of a frame (registered).

## Operation

Derived quantities:
- `ROW_LEN = IMG_WIDTH + 2*PAD_COLS`.
- `TOTAL_ROWS = IMG_HEIGHT + 2*PAD_ROWS + FLUSH_ROWS`.

Counters:
- `col` runs 0..`ROW_LEN`-1 and wraps to 0 at row end.
- `row` runs 0..`TOTAL_ROWS`-1.
- Both counters are 13 bits.
- Both advance only on cycles where an output pixel is produced.

State machine:
- **IDLE**
  - `oReady`=0; no output.
  - Moves to PAD on `iValid`=1. That pixel is not consumed; it stays held by the source.
- **PAD**: emits a zero pixel every cycle. It covers:
  - every column of rows below `PAD_ROWS`;
  - every column of rows at or above `PAD_ROWS + IMG_HEIGHT`;
  - columns below `PAD_COLS` or at or above `PAD_COLS + IMG_WIDTH` in the active rows.
- **BODY**
  - `oReady`=1.
  - On `iValid`&&`oReady`, registers `iData` to `oData` with `oValid`=1 and advances `col`.
  - With no `iValid` it produces no output and `col` holds (stall).
- **Transitions**
  - PAD and BODY switch purely on the next (`row`, `col`) position.
  - After the pixel at (`TOTAL_ROWS`-1, `ROW_LEN`-1), assert `oFrameDone`, clear both counters and return to IDLE.
- **Output ordering**: strictly raster; exactly `ROW_LEN*TOTAL_ROWS` pixels per frame.
- **Data rules**
  - Pad pixels are `24'h000000`.
  - Body pixels pass through bit-exact; no arithmetic is applied.
- **Boundary conditions**
  - `iValid` during PAD or IDLE→PAD: ignored. `oReady`=0, so the source must hold the pixel.
  - Last body pixel of a row: the next cycle is PAD (right border) with no bubble.
  - Last active row: bottom pad and flush rows follow without input.
  - Pixels offered after the final body pixel of a frame wait until the next frame starts from IDLE.
  - Reset mid-frame: the next cycle is IDLE with counters 0 and all outputs 0. The partial frame is abandoned; the downstream filter must be reset together with this block.

## Timing

- Reset values:
  - `oValid`=0, `oData`=0, `oFrameDone`=0, `oReady`=0.
  - State IDLE; `row`=`col`=0.
- `iValid` seen in IDLE at cycle t: first pad pixel has `oValid`=1 at t+2 (state update at t+1, output register at t+2).
- Latency: an accepted body pixel appears on `oData` exactly 1 cycle after acceptance.
- Pad pixels stream back-to-back at 1 per cycle.
- With an always-valid source, `oValid` stays continuously high for `ROW_LEN*TOTAL_ROWS` cycles.
- `oReady` is high only in BODY positions. It drops in the same cycle the state reaches a pad column.
- `oFrameDone` goes high in the same cycle as the final `oValid` of the frame; the cycle after, `oValid`=0.

## Test plan

1. **Always-valid source.** `IMG_WIDTH`=4, `IMG_HEIGHT`=3, defaults otherwise; source presents 1..12 with `iValid` held high.
   - Expect 36 contiguous valid pixels: row 0 all zero; rows 1-3 = `0,a,b,c,d,0`; rows 4-5 all zero.
   - Expect `oFrameDone` on the 36th pixel and exactly 12 `oReady`&&`iValid` handshakes.
2. **Bursty source.** Same frame; `iValid` toggles 1/0 every cycle.
   - Expect identical output data order; body pixels spaced by bubbles; pad pixels contiguous.
   - Expect `col`/`row` never advancing on stall cycles.
3. **Default sizes.** 320x240, always-valid source.
   - Expect 78246 output pixels (322x243).
   - Expect first active pixel at output index 323.
   - Expect `oFrameDone` pulse count = 1.
4. **Reset mid-body.** Assert `reset` for 1 cycle during row 2 of frame (1).
   - Next cycle `oValid`=0, `oReady`=0.
   - A new frame then produces the full 36-pixel pattern from the start.
5. **Back-to-back frames.** Source holds `iValid` high across the frame boundary.
   - Second frame begins after IDLE: `oValid` gap of exactly 2 cycles after `oFrameDone`.
   - Second frame's data is correct, with no pixel lost or duplicated.
6. **Extended pad.** `PAD_COLS`=2, `PAD_ROWS`=2, `FLUSH_ROWS`=0, 2x2 frame.
   - Expect 6x6 output: 2 zero rows, then `0,0,p0,p1,0,0` and `0,0,p2,p3,0,0`, then 2 zero rows.
